// File: rtl/morse_keyer.sv
// Morse sequencer: takes ASCII characters over valid/ready and drives the transmitter key.
// Dot = U, dash = 3U, element gap = U, character gap = 3U, space adds 4U; abort returns to IDLE at once.
module morse_keyer #(
  parameter real frequency = 60_000_000.0,
  parameter real unitTime  = 0.06
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] charData,
  input  logic       charValid,
  output logic       charReady,
  input  logic       abort,
  output logic       key,
  output logic       busy
);

  localparam int U  = int'(frequency * unitTime);
  localparam int CW = $clog2(4 * U + 1);

  localparam logic [CW-1:0] D1 = CW'(U - 1);
  localparam logic [CW-1:0] D3 = CW'(3 * U - 1);
  localparam logic [CW-1:0] D4 = CW'(4 * U - 1);

  generate
    if (U < 1) begin : g_bad_unit
      $error("morse_keyer: unitCycles must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, MARK, SYMGAP, CHARGAP, WORDGAP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [4:0]      pat, pat_n;
  logic [2:0]      rem, rem_n;
  logic            key_n;
  logic [7:0]      ent;
  logic [2:0]      len;
  logic [4:0]      left;

  // Returns {length, code}; code is right-aligned, first element in the highest used bit, 1 = dash.
  function automatic logic [7:0] lookup(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    case (u)
      "A": lookup = {3'd2, 5'b00001};
      "B": lookup = {3'd4, 5'b01000};
      "C": lookup = {3'd4, 5'b01010};
      "D": lookup = {3'd3, 5'b00100};
      "E": lookup = {3'd1, 5'b00000};
      "F": lookup = {3'd4, 5'b00010};
      "G": lookup = {3'd3, 5'b00110};
      "H": lookup = {3'd4, 5'b00000};
      "I": lookup = {3'd2, 5'b00000};
      "J": lookup = {3'd4, 5'b00111};
      "K": lookup = {3'd3, 5'b00101};
      "L": lookup = {3'd4, 5'b00100};
      "M": lookup = {3'd2, 5'b00011};
      "N": lookup = {3'd2, 5'b00010};
      "O": lookup = {3'd3, 5'b00111};
      "P": lookup = {3'd4, 5'b00110};
      "Q": lookup = {3'd4, 5'b01101};
      "R": lookup = {3'd3, 5'b00010};
      "S": lookup = {3'd3, 5'b00000};
      "T": lookup = {3'd1, 5'b00001};
      "U": lookup = {3'd3, 5'b00001};
      "V": lookup = {3'd4, 5'b00001};
      "W": lookup = {3'd3, 5'b00011};
      "X": lookup = {3'd4, 5'b01001};
      "Y": lookup = {3'd4, 5'b01011};
      "Z": lookup = {3'd4, 5'b01100};
      "0": lookup = {3'd5, 5'b11111};
      "1": lookup = {3'd5, 5'b01111};
      "2": lookup = {3'd5, 5'b00111};
      "3": lookup = {3'd5, 5'b00011};
      "4": lookup = {3'd5, 5'b00001};
      "5": lookup = {3'd5, 5'b00000};
      "6": lookup = {3'd5, 5'b10000};
      "7": lookup = {3'd5, 5'b11000};
      "8": lookup = {3'd5, 5'b11100};
      "9": lookup = {3'd5, 5'b11110};
      default: lookup = 8'd0;
    endcase
  endfunction

  assign charReady = (state == IDLE) & ~reset & ~abort;
  assign ent       = lookup(charData);
  assign len       = ent[7:5];
  assign left      = ent[4:0] << (3'd5 - len);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_n   = pat;
    rem_n   = rem;
    key_n   = 1'b0;
    case (state)
      IDLE: begin
        if (charValid && charReady) begin
          if (len != 3'd0) begin
            state_n = MARK;
            key_n   = 1'b1;
            pat_n   = left;
            rem_n   = len;
            cnt_n   = left[4] ? D3 : D1;
          end else if (charData == 8'h20) begin
            state_n = WORDGAP;
            cnt_n   = D4;
          end
        end
      end
      MARK: begin
        key_n = 1'b1;
        if (cnt == '0) begin
          key_n = 1'b0;
          if (rem > 3'd1) begin
            state_n = SYMGAP;
            cnt_n   = D1;
            rem_n   = rem - 3'd1;
            pat_n   = {pat[3:0], 1'b0};
          end else begin
            state_n = CHARGAP;
            cnt_n   = D3;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      SYMGAP: begin
        if (cnt == '0) begin
          state_n = MARK;
          key_n   = 1'b1;
          cnt_n   = pat[4] ? D3 : D1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      CHARGAP, WORDGAP: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
    // Abort drops whatever is left of the character without a trailing gap.
    if (abort) begin
      state_n = IDLE;
      key_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pat   <= '0;
      rem   <= '0;
      key   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pat   <= pat_n;
      rem   <= rem_n;
      key   <= key_n;
      busy  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer with U=4: directed timing scenarios plus a random character stream
// checked against a dot/dash string model of the expected key waveform.
module tb_morse_keyer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] charData = 8'd0;
  logic       charValid = 1'b0;
  logic       charReady;
  logic       abort = 1'b0;
  logic       key;
  logic       busy;

  int total = 0;
  int bad = 0;

  string tbl [0:35];
  bit    exp_q[$];

  morse_keyer #(.frequency(1000.0), .unitTime(0.004)) dut (
    .clk(clk), .reset(reset), .charData(charData), .charValid(charValid),
    .charReady(charReady), .abort(abort), .key(key), .busy(busy)
  );

  always #5 clk = ~clk;

  // Appends the per-cycle key values a character produces after it is accepted.
  function automatic void push_char(input logic [7:0] c);
    logic [7:0] u;
    string s;
    s = "";
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    if (u == 8'h20) begin
      repeat (4 * U) exp_q.push_back(1'b0);
      return;
    end
    if (u >= "A" && u <= "Z") s = tbl[u - 8'd65];
    else if (u >= "0" && u <= "9") s = tbl[26 + u - 8'd48];
    if (s.len() == 0) return;
    for (int i = 0; i < s.len(); i++) begin
      repeat ((s[i] == "-") ? 3 * U : U) exp_q.push_back(1'b1);
      if (i < s.len() - 1) repeat (U) exp_q.push_back(1'b0);
    end
    repeat (3 * U) exp_q.push_back(1'b0);
  endfunction

  function automatic logic [7:0] pick();
    string odd;
    int r;
    odd = "#!?.,@~";
    r = $urandom_range(0, 9);
    if (r <= 3) return 8'(8'd65 + $urandom_range(0, 25));
    if (r <= 5) return 8'(8'd97 + $urandom_range(0, 25));
    if (r <= 7) return 8'(8'd48 + $urandom_range(0, 9));
    if (r == 8) return 8'h20;
    return odd[$urandom_range(0, 6)];
  endfunction

  task automatic test_reset();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      reset = (c < 3);
      #1;
      if (c > 0) begin
        total += 3;
        if (charReady !== (c >= 3)) begin bad++; $display("FAIL reset ready c=%0d got=%b exp=%b", c, charReady, (c >= 3)); end
        if (key !== 1'b0) begin bad++; $display("FAIL reset key c=%0d got=%b exp=0", c, key); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy c=%0d got=%b exp=0", c, busy); end
      end
    end
  endtask

  task automatic test_dot_e();
    logic ek, eb, er;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      charValid = (c == 0);
      charData  = "E";
      #1;
      ek = (c >= 1 && c <= 4);
      eb = (c >= 1 && c <= 16);
      er = (c == 0 || c >= 17);
      total += 3;
      if (key !== ek) begin bad++; $display("FAIL dotE key c=%0d got=%b exp=%b", c, key, ek); end
      if (busy !== eb) begin bad++; $display("FAIL dotE busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (charReady !== er) begin bad++; $display("FAIL dotE ready c=%0d got=%b exp=%b", c, charReady, er); end
    end
  endtask

  task automatic test_lower_a();
    logic ek, eb, er;
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      charValid = (c == 0);
      charData  = "a";
      #1;
      ek = (c >= 1 && c <= 4) || (c >= 9 && c <= 20);
      eb = (c >= 1 && c <= 32);
      er = (c == 0 || c >= 33);
      total += 3;
      if (key !== ek) begin bad++; $display("FAIL lowerA key c=%0d got=%b exp=%b", c, key, ek); end
      if (busy !== eb) begin bad++; $display("FAIL lowerA busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (charReady !== er) begin bad++; $display("FAIL lowerA ready c=%0d got=%b exp=%b", c, charReady, er); end
    end
  endtask

  task automatic test_back_to_back();
    string s;
    int idx;
    logic ek, eb, er;
    s = "E E";
    idx = 0;
    for (int c = 0; c <= 52; c++) begin
      @(negedge clk);
      charValid = (idx < 3);
      charData  = (idx < 3) ? s[idx] : 8'd0;
      #1;
      ek = (c >= 1 && c <= 4) || (c >= 35 && c <= 38);
      eb = (c >= 1 && c <= 16) || (c >= 18 && c <= 33) || (c >= 35 && c <= 50);
      er = (c == 0 || c == 17 || c == 34 || c >= 51);
      total += 3;
      if (key !== ek) begin bad++; $display("FAIL stream key c=%0d got=%b exp=%b", c, key, ek); end
      if (busy !== eb) begin bad++; $display("FAIL stream busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (charReady !== er) begin bad++; $display("FAIL stream ready c=%0d got=%b exp=%b", c, charReady, er); end
      if (charValid && charReady) idx++;
    end
  endtask

  task automatic test_unsupported();
    logic ek, eb, er;
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      charValid = (c <= 1);
      charData  = (c == 0) ? "#" : "T";
      #1;
      ek = (c >= 2 && c <= 13);
      eb = (c >= 2 && c <= 25);
      er = (c <= 1 || c >= 26);
      total += 3;
      if (key !== ek) begin bad++; $display("FAIL unsup key c=%0d got=%b exp=%b", c, key, ek); end
      if (busy !== eb) begin bad++; $display("FAIL unsup busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (charReady !== er) begin bad++; $display("FAIL unsup ready c=%0d got=%b exp=%b", c, charReady, er); end
    end
  endtask

  task automatic test_abort();
    logic ek, eb, er;
    @(negedge clk);
    abort = 1'b1; charValid = 1'b1; charData = "E";
    #1;
    total += 1;
    if (charReady !== 1'b0) begin bad++; $display("FAIL abort_idle ready got=%b exp=0", charReady); end
    @(negedge clk);
    abort = 1'b0; charValid = 1'b0;
    #1;
    total += 2;
    if (key !== 1'b0) begin bad++; $display("FAIL abort_idle key got=%b exp=0", key); end
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle busy got=%b exp=0", busy); end
    for (int c = 0; c <= 39; c++) begin
      @(negedge clk);
      charValid = (c == 0 || c == 21);
      charData  = (c == 0) ? "0" : "E";
      abort     = (c == 20);
      #1;
      ek = (c >= 1 && c <= 12) || (c >= 17 && c <= 20) || (c >= 22 && c <= 25);
      eb = (c >= 1 && c <= 20) || (c >= 22 && c <= 37);
      er = (c == 0 || c == 21 || c >= 38);
      total += 3;
      if (key !== ek) begin bad++; $display("FAIL abort key c=%0d got=%b exp=%b", c, key, ek); end
      if (busy !== eb) begin bad++; $display("FAIL abort busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (charReady !== er) begin bad++; $display("FAIL abort ready c=%0d got=%b exp=%b", c, charReady, er); end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ek, eb, er;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      charValid = (c == 0);
      charData  = "T";
      reset     = (c == 10);
      #1;
      ek = (c >= 1 && c <= 10);
      eb = (c >= 1 && c <= 10);
      er = (c == 0 || c >= 11);
      total += 3;
      if (key !== ek) begin bad++; $display("FAIL rstmid key c=%0d got=%b exp=%b", c, key, ek); end
      if (busy !== eb) begin bad++; $display("FAIL rstmid busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (charReady !== er) begin bad++; $display("FAIL rstmid ready c=%0d got=%b exp=%b", c, charReady, er); end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic       ek, eb, er;
    logic       pend;
    logic [7:0] pc;
    pend = 1'b0;
    pc   = 8'd0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!pend && c < 2800 && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        pc   = pick();
      end
      charValid = pend;
      charData  = pend ? pc : 8'($urandom);
      #1;
      if (exp_q.size() == 0) begin
        ek = 1'b0; eb = 1'b0; er = 1'b1;
        if (pend) begin
          push_char(pc);
          pend = 1'b0;
        end
      end else begin
        ek = exp_q.pop_front(); eb = 1'b1; er = 1'b0;
      end
      total += 3;
      if (key !== ek) begin bad++; $display("FAIL rand key c=%0d got=%b exp=%b", c, key, ek); end
      if (busy !== eb) begin bad++; $display("FAIL rand busy c=%0d got=%b exp=%b", c, busy, eb); end
      if (charReady !== er) begin bad++; $display("FAIL rand ready c=%0d got=%b exp=%b", c, charReady, er); end
    end
    charValid = 1'b0;
  endtask

  initial begin
    tbl = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
            "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
            "..-", "...-", ".--", "-..-", "-.--", "--..",
            "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};
    test_reset();
    test_dot_e();
    test_lower_a();
    test_back_to_back();
    test_unsupported();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
